// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multicycle CPU control unit:
// FSM state encoding, opcode map, ALU operation codes and the packed
// bundle of registered control strobes.
package cpu_ctrl_pkg;

  localparam int CPU_OPW         = 4;   // opcode width, instr[7:4]
  localparam int CPU_ALUW        = 3;   // alu_op width
  localparam int CPU_MEM_TIMEOUT = 15;  // max wait cycles on mem_ready
  localparam int CPU_TOW         = 4;   // timeout counter width

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  localparam logic [CPU_OPW-1:0] OP_NOP  = 4'h0;
  localparam logic [CPU_OPW-1:0] OP_ADD  = 4'h1;
  localparam logic [CPU_OPW-1:0] OP_SUB  = 4'h2;
  localparam logic [CPU_OPW-1:0] OP_AND  = 4'h3;
  localparam logic [CPU_OPW-1:0] OP_OR   = 4'h4;
  localparam logic [CPU_OPW-1:0] OP_MOV  = 4'h5;
  localparam logic [CPU_OPW-1:0] OP_LD   = 4'h6;
  localparam logic [CPU_OPW-1:0] OP_ST   = 4'h7;
  localparam logic [CPU_OPW-1:0] OP_BEQZ = 4'h8;
  localparam logic [CPU_OPW-1:0] OP_HALT = 4'hF;

  localparam logic [CPU_ALUW-1:0] ALU_ADD  = 3'd0;
  localparam logic [CPU_ALUW-1:0] ALU_SUB  = 3'd1;
  localparam logic [CPU_ALUW-1:0] ALU_AND  = 3'd2;
  localparam logic [CPU_ALUW-1:0] ALU_OR   = 3'd3;
  localparam logic [CPU_ALUW-1:0] ALU_PASS = 3'd4;

  // Every registered control strobe driven towards the datapath.
  typedef struct packed {
    logic                ir_load;
    logic                pc_en;
    logic                pc_sel;
    logic                rs;
    logic                rd;
    logic [CPU_ALUW-1:0] alu_op;
    logic                reg_we;
    logic                wb_sel;
    logic                mem_re;
    logic                mem_we;
  } ctrl_t;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Purely combinational instruction decoder: maps the IR opcode field to
// the ALU operation and the instruction-class flags the FSM branches on.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW  = CPU_OPW,
  parameter int ALUW = CPU_ALUW
) (
  input  logic [OPW-1:0]  opcode,
  output logic [ALUW-1:0] alu_op,
  output logic            is_ld,
  output logic            is_st,
  output logic            is_br,
  output logic            is_halt,
  output logic            illegal
);

  // Opcode to ALU operation and class flags.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    alu_op  = ALU_ADD;
    is_ld   = 1'b0;
    is_st   = 1'b0;
    is_br   = 1'b0;
    is_halt = 1'b0;
    illegal = 1'b0;
    unique case (opcode)
      OP_NOP:  ;
      OP_ADD:  alu_op = ALU_ADD;
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      OP_OR:   alu_op = ALU_OR;
      OP_MOV:  alu_op = ALU_PASS;
      OP_LD:   is_ld = 1'b1;
      OP_ST:   is_st = 1'b1;
      OP_BEQZ: is_br = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle control unit for the 8-bit accumulator CPU. Sequences each
// instruction through FETCH/DECODE/EXEC/MEM/WB and drives registered
// datapath strobes, decoded from the next state so they line up with the
// cycle the state is entered. Data memory is handshaken via mem_ready
// with a bounded wait.
// Optional build macro: CPU_CTRL_PERF_EN adds saturating cycle_cnt and
// instr_cnt performance counters.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW         = CPU_OPW,
  parameter int ALUW        = CPU_ALUW,
  parameter int MEM_TIMEOUT = CPU_MEM_TIMEOUT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [7:0]      instr,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            ir_load,
  output logic            pc_en,
  output logic            pc_sel,
  output logic            rs,
  output logic            rd,
  output logic [ALUW-1:0] alu_op,
  output logic            reg_we,
  output logic            wb_sel,
  output logic            mem_re,
  output logic            mem_we,
  output logic            halted,
  output logic            err
`ifdef CPU_CTRL_PERF_EN
  ,
  output logic [15:0]     cycle_cnt,
  output logic [15:0]     instr_cnt
`endif
);

  localparam logic [CPU_TOW-1:0] TMO_LAST = CPU_TOW'(MEM_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic                started_q, started_d;  // first real fetch issued since reset
  logic [7:0]          ir_q, ir_d;
  logic [CPU_TOW-1:0]  tmo_q, tmo_d;
  ctrl_t               ctrl_q, ctrl_d;
  logic                halted_q, halted_d;
  logic                err_q, err_d;

  logic [OPW-1:0]      opcode;
  logic [ALUW-1:0]     dec_alu_op;
  logic                dec_ld, dec_st, dec_br, dec_halt, dec_illegal;
  logic                unused_ir_bits;

  // The branch offset bits are consumed by the datapath, not here.
  assign unused_ir_bits = ^ir_q[1:0];
  assign opcode         = ir_q[7 -: OPW];

  cpu_ctrl_decode #(
    .OPW  (OPW),
    .ALUW (ALUW)
  ) u_decode (
    .opcode  (opcode),
    .alu_op  (dec_alu_op),
    .is_ld   (dec_ld),
    .is_st   (dec_st),
    .is_br   (dec_br),
    .is_halt (dec_halt),
    .illegal (dec_illegal)
  );

  // State, IR, timeout counter and output registers.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state is only ever assigned with <= so every flop
    // samples the values from before this edge regardless of order.
    if (RST) begin
      state_q   <= FETCH;
      started_q <= 1'b0;
      ir_q      <= '0;
      tmo_q     <= '0;
      ctrl_q    <= '0;
      halted_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= started_d;
      ir_q      <= ir_d;
      tmo_q     <= tmo_d;
      ctrl_q    <= ctrl_d;
      halted_q  <= halted_d;
      err_q     <= err_d;
    end
  end

  // Next-state, IR capture, memory wait counting and sticky flags.
  always_comb begin
    state_d   = state_q;
    started_d = started_q;
    ir_d      = ir_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    unique case (state_q)
      FETCH: begin
        // The reset cycle sits in FETCH with no strobes; the real fetch
        // happens in the following cycle.
        started_d = 1'b1;
        if (started_q) begin
          ir_d    = instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (dec_halt) begin
          state_d = HALT;
        end else if (dec_illegal) begin
          err_d   = 1'b1;
          state_d = FETCH;
        end else if (opcode == OP_NOP) begin
          state_d = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        tmo_d = '0;
        if (dec_ld || dec_st) state_d = MEM;
        else if (dec_br)      state_d = FETCH;
        else                  state_d = WB;
      end
      MEM: begin
        // Completion is checked first so it wins over a coincident timeout.
        if (mem_ready) begin
          tmo_d   = '0;
          state_d = dec_ld ? WB : FETCH;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          err_d   = 1'b1;
          state_d = FETCH;
        end else begin
          tmo_d = tmo_q + CPU_TOW'(1);
        end
      end
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
    halted_d = halted_q | (state_d == HALT);
  end

  // Strobes for the state about to be entered.
  always_comb begin
    ctrl_d = '0;
    unique case (state_d)
      FETCH: begin
        ctrl_d.ir_load = 1'b1;
        ctrl_d.pc_en   = 1'b1;
      end
      DECODE: begin
        ctrl_d.rs = ir_d[2];
        ctrl_d.rd = ir_d[3];
      end
      EXEC: begin
        ctrl_d.rs     = ir_d[2];
        ctrl_d.rd     = ir_d[3];
        ctrl_d.alu_op = dec_alu_op;
        if (dec_br && zero) begin
          ctrl_d.pc_en  = 1'b1;
          ctrl_d.pc_sel = 1'b1;
        end
      end
      MEM: begin
        ctrl_d.rs     = ir_d[2];
        ctrl_d.rd     = ir_d[3];
        ctrl_d.mem_re = dec_ld;
        ctrl_d.mem_we = dec_st;
      end
      WB: begin
        ctrl_d.rs     = ir_d[2];
        ctrl_d.rd     = ir_d[3];
        ctrl_d.reg_we = 1'b1;
        ctrl_d.wb_sel = dec_ld;
      end
      HALT:    ctrl_d = '0;
      default: ctrl_d = '0;
    endcase
  end

  assign ir_load = ctrl_q.ir_load;
  assign pc_en   = ctrl_q.pc_en;
  assign pc_sel  = ctrl_q.pc_sel;
  assign rs      = ctrl_q.rs;
  assign rd      = ctrl_q.rd;
  assign alu_op  = ctrl_q.alu_op;
  assign reg_we  = ctrl_q.reg_we;
  assign wb_sel  = ctrl_q.wb_sel;
  assign mem_re  = ctrl_q.mem_re;
  assign mem_we  = ctrl_q.mem_we;
  assign halted  = halted_q;
  assign err     = err_q;

`ifdef CPU_CTRL_PERF_EN
  logic [15:0] cycle_cnt_q, cycle_cnt_d;
  logic [15:0] instr_cnt_q, instr_cnt_d;

  // Saturating counts of running cycles and completed instructions.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (state_q != HALT && cycle_cnt_q != 16'hFFFF)
      cycle_cnt_d = cycle_cnt_q + 16'd1;
    if (state_d == FETCH && state_q != FETCH && instr_cnt_q != 16'hFFFF)
      instr_cnt_d = instr_cnt_q + 16'd1;
  end

  // Performance counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm. Expected output vectors are pushed to a
// scoreboard queue as each step is driven and popped one per clock,
// sampled 1 time unit after the rising edge.
module tb_cpu_ctrl_fsm;

  logic       CLK;
  logic       RST;
  logic [7:0] instr;
  logic       zero;
  logic       mem_ready;
  logic       ir_load, pc_en, pc_sel, rs, rd;
  logic [2:0] alu_op;
  logic       reg_we, wb_sel, mem_re, mem_we, halted, err;

  typedef struct packed {
    logic       ir_load;
    logic       pc_en;
    logic       pc_sel;
    logic       rs;
    logic       rd;
    logic [2:0] alu_op;
    logic       reg_we;
    logic       wb_sel;
    logic       mem_re;
    logic       mem_we;
    logic       halted;
    logic       err;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  v;
  } sb_t;

  sb_t  sb[$];
  int   errors = 0;
  int   checks = 0;
  logic exp_err;
  logic exp_halted;

  cpu_ctrl_fsm dut (
    .CLK       (CLK),
    .RST       (RST),
    .instr     (instr),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ir_load   (ir_load),
    .pc_en     (pc_en),
    .pc_sel    (pc_sel),
    .rs        (rs),
    .rd        (rd),
    .alu_op    (alu_op),
    .reg_we    (reg_we),
    .wb_sel    (wb_sel),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .halted    (halted),
    .err       (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // All strobes low, sticky flags as currently expected.
  function automatic obs_t base();
    obs_t v = '0;
    v.err    = exp_err;
    v.halted = exp_halted;
    return v;
  endfunction

  function automatic obs_t x_fetch();
    obs_t v = base();
    v.ir_load = 1'b1;
    v.pc_en   = 1'b1;
    return v;
  endfunction

  // Register selects taken from IR[2] (rs) and IR[3] (rd).
  function automatic obs_t x_regs(input logic [7:0] ir);
    obs_t v = base();
    v.rs = ir[2];
    v.rd = ir[3];
    return v;
  endfunction

  task automatic sb_push(input string tag, input obs_t v);
    sb_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    sb_t  e;
    obs_t got;
    @(posedge CLK);
    #1;
    got = {ir_load, pc_en, pc_sel, rs, rd, alu_op, reg_we, wb_sel,
           mem_re, mem_we, halted, err};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%h expected=<none>", got);
    end else begin
      e = sb.pop_front();
      assert (got === e.v) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, got, e.v);
      end
    end
  endtask

  initial begin
    obs_t v;
    RST        = 1'b1;
    instr      = 8'h1C;
    zero       = 1'b0;
    mem_ready  = 1'b0;
    exp_err    = 1'b0;
    exp_halted = 1'b0;

    sb_push("reset", base());       tick();
    sb_push("reset_hold", base());  tick();
    RST = 1'b0;

    // ADD rd=1 rs=1
    sb_push("add_fetch", x_fetch());        tick();
    sb_push("add_decode", x_regs(8'h1C));   tick();
    v = x_regs(8'h1C); v.alu_op = 3'd0;
    sb_push("add_exec", v);                 tick();
    v = x_regs(8'h1C); v.reg_we = 1'b1;
    sb_push("add_wb", v);                   tick();
    instr = 8'h60;
    sb_push("add_next_fetch", x_fetch());   tick();

    // LD with three wait cycles
    sb_push("ld_decode", x_regs(8'h60));    tick();
    sb_push("ld_exec", x_regs(8'h60));      tick();
    v = x_regs(8'h60); v.mem_re = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb_push("ld_mem", v);                 tick();
    end
    mem_ready = 1'b1;
    v = x_regs(8'h60); v.reg_we = 1'b1; v.wb_sel = 1'b1;
    sb_push("ld_wb", v);                    tick();
    mem_ready = 1'b0;
    instr = 8'h81;
    zero  = 1'b1;
    sb_push("ld_next_fetch", x_fetch());    tick();

    // BEQZ taken
    sb_push("beqz_t_decode", x_regs(8'h81)); tick();
    v = x_regs(8'h81); v.pc_en = 1'b1; v.pc_sel = 1'b1;
    sb_push("beqz_t_exec", v);              tick();
    zero = 1'b0;
    sb_push("beqz_t_fetch", x_fetch());     tick();

    // BEQZ not taken
    sb_push("beqz_nt_decode", x_regs(8'h81)); tick();
    sb_push("beqz_nt_exec", x_regs(8'h81));   tick();
    instr = 8'h70;
    sb_push("beqz_nt_fetch", x_fetch());    tick();

    // ST with mem_ready never asserted: timeout after 15 wait cycles
    sb_push("st_decode", x_regs(8'h70));    tick();
    sb_push("st_exec", x_regs(8'h70));      tick();
    v = x_regs(8'h70); v.mem_we = 1'b1;
    for (int i = 0; i < 15; i++) begin
      sb_push("st_mem_wait", v);            tick();
    end
    exp_err = 1'b1;
    instr   = 8'h6C;
    sb_push("st_timeout_fetch", x_fetch()); tick();

    // LD interrupted by reset while waiting in MEM
    sb_push("ldr_decode", x_regs(8'h6C));   tick();
    sb_push("ldr_exec", x_regs(8'h6C));     tick();
    v = x_regs(8'h6C); v.mem_re = 1'b1;
    sb_push("ldr_mem1", v);                 tick();
    sb_push("ldr_mem2", v);                 tick();
    RST     = 1'b1;
    exp_err = 1'b0;
    sb_push("ldr_reset", base());           tick();
    RST   = 1'b0;
    instr = 8'hA0;
    sb_push("ldr_restart_fetch", x_fetch()); tick();

    // Illegal opcode: err set, executes as NOP
    sb_push("ill_decode", x_regs(8'hA0));   tick();
    exp_err = 1'b1;
    instr   = 8'h00;
    sb_push("ill_fetch", x_fetch());        tick();

    // NOP with a stray mem_ready that must be ignored
    mem_ready = 1'b1;
    sb_push("nop_decode", x_regs(8'h00));   tick();
    mem_ready = 1'b0;
    instr = 8'h58;
    sb_push("nop_fetch", x_fetch());        tick();

    // MOV rd=1 rs=0
    sb_push("mov_decode", x_regs(8'h58));   tick();
    v = x_regs(8'h58); v.alu_op = 3'd4;
    sb_push("mov_exec", v);                 tick();
    v = x_regs(8'h58); v.reg_we = 1'b1;
    sb_push("mov_wb", v);                   tick();
    instr = 8'hF0;
    sb_push("mov_fetch", x_fetch());        tick();

    // HALT: sticky, strobes quiet, inputs ignored
    sb_push("halt_decode", x_regs(8'hF0));  tick();
    exp_halted = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      zero      = i[1];
      instr     = 8'h1C;
      sb_push("halt_hold", base());         tick();
    end

    // Only reset leaves HALT
    RST        = 1'b1;
    exp_err    = 1'b0;
    exp_halted = 1'b0;
    sb_push("halt_reset", base());          tick();
    RST = 1'b0;
    sb_push("halt_restart_fetch", x_fetch()); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
